// File: rtl/wb_dest_scoreboard.sv
// Destination-register scoreboard for long-latency (mult/div) writes: tracks pending
// destinations and stalls decode on RAW/WAW/resource hazards. Optional macro: SCOREBOARD_BYPASS_EN.
module wb_dest_scoreboard #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic             issue_long,
  input  logic             issue_wen,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic             done_valid,
  input  logic [4:0]       done_rd,
  input  logic             flush,
  output logic             stall,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding,
  output logic             full,
  output logic             err_done
);

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_done_q, err_done_d;

  logic [31:0] done_mask;
  logic [31:0] set_mask;
  logic [31:0] pend_eff;
  logic        done_hit;
  logic        raw, waw, res;
  logic        acc, set, clr;

  assign full     = (outstanding_q == CNT_W'(MAX_OUTSTANDING));
  assign done_hit = done_valid & pending_q[done_rd];

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      assign done_mask[gi] = done_valid & (done_rd == 5'(gi));
      assign set_mask[gi]  = set & (issue_rd == 5'(gi));
`ifdef SCOREBOARD_BYPASS_EN
      // Register file write-through forwards the completing value in the done cycle.
      assign pend_eff[gi]  = pending_q[gi] & ~done_mask[gi];
`else
      assign pend_eff[gi]  = pending_q[gi];
`endif
    end
  endgenerate

  assign raw = (rs1_used & pend_eff[rs1]) | (rs2_used & pend_eff[rs2]);
  assign waw = issue_wen & pend_eff[issue_rd];
`ifdef SCOREBOARD_BYPASS_EN
  // A slot retiring this cycle may be reused by the incoming long op.
  assign res = issue_long & issue_wen & full & ~done_hit;
`else
  assign res = issue_long & issue_wen & full;
`endif

  assign stall = issue_valid & ~flush & (raw | waw | res);
  assign acc   = issue_valid & ~stall & ~flush;
  assign set   = acc & issue_long & issue_wen & (issue_rd != 5'd0);
  assign clr   = done_hit & ~flush;

  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    err_done_d    = 1'b0;
    if (flush) begin
      pending_d     = '0;
      outstanding_d = '0;
    end else begin
      // Clear before set so a same-register retire/re-issue leaves the bit set.
      for (int i = 0; i < 32; i++) begin
        if (clr && done_mask[i]) pending_d[i] = 1'b0;
        if (set_mask[i])         pending_d[i] = 1'b1;
      end
      pending_d[0] = 1'b0;
      case ({set, clr})
        2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
        2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
        default: outstanding_d = outstanding_q;
      endcase
      err_done_d = done_valid & ((done_rd == 5'd0) | ~pending_q[done_rd]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      err_done_q    <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_done_q    <= err_done_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign err_done    = err_done_q;

endmodule

// File: tb/tb_wb_dest_scoreboard.sv
// Directed-vector bench for wb_dest_scoreboard: stimulus pushes hand-computed expectations
// into a queue; a negedge monitor pops and compares them against the DUT.
module tb_wb_dest_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_long, issue_wen;
  logic [4:0]  issue_rd, rs1, rs2, done_rd;
  logic        rs1_used, rs2_used, done_valid, flush;
  logic        stall, full, err_done;
  logic [31:0] pending;
  logic [1:0]  outstanding;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        stall;
    logic [31:0] pend;
    logic [1:0]  outs;
    logic        full;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  wb_dest_scoreboard #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_long  (issue_long),
    .issue_wen   (issue_wen),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .done_valid  (done_valid),
    .done_rd     (done_rd),
    .flush       (flush),
    .stall       (stall),
    .pending     (pending),
    .outstanding (outstanding),
    .full        (full),
    .err_done    (err_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, expv);
    end else begin
      $display("ok   %s.%s = 0x%0h", nm, fld, act);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, away from the rising edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.nm, "stall",       32'(stall),       32'(e.stall));
      check(e.nm, "pending",     pending,          e.pend);
      check(e.nm, "outstanding", 32'(outstanding), 32'(e.outs));
      check(e.nm, "full",        32'(full),        32'(e.full));
      check(e.nm, "err_done",    32'(err_done),    32'(e.err));
    end
  end

  // One cycle of stimulus plus its expected observation (stall is combinational;
  // pending/outstanding/full/err_done reflect the previous edge).
  task automatic cyc(input string nm, input logic rn,
                     input logic iv, input logic il, input logic iw, input logic [4:0] ird,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic dv, input logic [4:0] drd, input logic fl,
                     input logic e_stall, input logic [31:0] e_pend, input logic [1:0] e_outs,
                     input logic e_full, input logic e_err);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n     = rn;
    issue_valid = iv;
    issue_long  = il;
    issue_wen   = iw;
    issue_rd    = ird;
    rs1         = r1;
    rs1_used    = u1;
    rs2         = r2;
    rs2_used    = u2;
    done_valid  = dv;
    done_rd     = drd;
    flush       = fl;
    e.nm    = nm;
    e.stall = e_stall;
    e.pend  = e_pend;
    e.outs  = e_outs;
    e.full  = e_full;
    e.err   = e_err;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0;
    {issue_valid, issue_long, issue_wen, rs1_used, rs2_used, done_valid, flush} = '0;
    {issue_rd, rs1, rs2, done_rd} = '0;
    repeat (2) @(posedge clock);

    //          name          rn iv il iw ird  rs1 u1 rs2 u2 dv drd fl  stall pend          out full err
    cyc("in_reset",     0, 1, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("rst_idle",     1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("iss_l5",       1, 1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("raw5",         1, 1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 1, 32'h20,    2'd1, 0, 0);
`ifdef SCOREBOARD_BYPASS_EN
    cyc("raw5_done",    1, 1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 1, 5'd5, 0, 0, 32'h20,    2'd1, 0, 0);
`else
    cyc("raw5_done",    1, 1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 1, 5'd5, 0, 1, 32'h20,    2'd1, 0, 0);
`endif
    cyc("raw5_rel",     1, 1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("iss_l0",       1, 1, 1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("use_r0",       1, 1, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("iss_l3",       1, 1, 1, 1, 5'd3, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("iss_l4",       1, 1, 1, 1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h8,     2'd1, 0, 0);
    cyc("full_obs",     1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h18,    2'd2, 1, 0);
    cyc("res6",         1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 32'h18,    2'd2, 1, 0);
`ifdef SCOREBOARD_BYPASS_EN
    cyc("res6_done3",   1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 1, 5'd3, 0, 0, 32'h18,    2'd2, 1, 0);
    cyc("res6_retry",   1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 32'h50,    2'd2, 1, 0);
`else
    cyc("res6_done3",   1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 1, 5'd3, 0, 1, 32'h18,    2'd2, 1, 0);
    cyc("res6_retry",   1, 1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h10,    2'd1, 0, 0);
`endif
    cyc("flush_done4",  1, 1, 1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 0, 32'h50,    2'd2, 1, 0);
    cyc("post_flush",   1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("iss_l7",       1, 1, 1, 1, 5'd7, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("waw7",         1, 1, 0, 1, 5'd7, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 32'h80,    2'd1, 0, 0);
    cyc("nowaw7",       1, 1, 0, 0, 5'd7, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h80,    2'd1, 0, 0);
    cyc("bad9",         1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0, 32'h80,    2'd1, 0, 0);
    cyc("err9_pulse",   1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h80,    2'd1, 0, 1);
    cyc("err9_clear",   1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h80,    2'd1, 0, 0);
    cyc("bad0",         1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 32'h80,    2'd1, 0, 0);
    cyc("err0_pulse",   1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h80,    2'd1, 0, 1);
    cyc("iss_l8",       1, 1, 1, 1, 5'd8, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h80,    2'd1, 0, 0);
    cyc("pre_reset",    1, 1, 0, 0, 5'd0, 5'd7, 1, 5'd8, 1, 0, 5'd0, 0, 1, 32'h180,   2'd2, 1, 0);
    cyc("reset_mid",    0, 1, 0, 0, 5'd0, 5'd7, 1, 5'd8, 1, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("after_rst",    1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);
    cyc("after_rst2",   1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 32'h0,     2'd0, 0, 0);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge clock);
        budget++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
    end
    @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
